reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back arbiter for the MIPS_32 datapath that owns the single register-file write port (address, data, write enable). It accepts single-cycle ALU results and variable-latency load returns, buffers loads in a small FIFO, and commits at most one write per cycle. An optional scoreboard tracks registers with loads in flight so decode can stall on RAW hazards.

## Interface
- DEPTH, 4: load-return FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive blocked cycles of the FIFO head before the ALU is throttled.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_dst  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  FIFO can accept a load return.
- ld_dst  in  5  load destination register.
- ld_data  in  32  load data.
- iss_valid  in  1  a load issued this cycle; marks its destination pending.
- iss_dst  in  5  destination of the issued load.
- pending  out  32  one bit per register with a load in flight.
- wr_en  out  1  register-file write enable.
- wr_addr  out  5  register-file write address.
- wr_data  out  32  register-file write data.

## Operation
- ALU transfer: alu_valid && alu_ready. Load transfer: ld_valid && ld_ready.
- ld_ready = (count < DEPTH). There is no same-cycle pop credit, so a full FIFO refuses a push even while it pops.
- Arbitration each cycle:
  - An accepted ALU result wins the write port.
  - Otherwise, a non-empty FIFO pops its head onto the port.
  - A load arriving into an empty FIFO is stored first and is not written the same cycle.
- Starvation counter:
  - Increments when the FIFO is non-empty and loses to the ALU. Resets to 0 on any FIFO pop or when the FIFO is empty.
  - alu_ready = !(starve_cnt == STARVE_LIMIT). When it is 0, the FIFO head is guaranteed the port that cycle.
- Register 0:
  - A write whose destination is 0 still consumes its transfer and FIFO slot, but drives wr_en=0 for that slot.
  - iss_dst=0 never sets pending.
- Simultaneous FIFO push and pop: count is unchanged and pointers each advance by one, modulo DEPTH.
- Ordering: ALU and load writes to the same register commit in arbitration order. Decode must use pending to prevent WAW.

## Timing
- Write port outputs are registered. A transfer in cycle N drives wr_en/wr_addr/wr_data in cycle N+1 for exactly one cycle.
- ALU-to-register-file latency is 1 cycle. Load latency is at least 2 cycles (push, then pop, then registered write).
- Throughput is one write per cycle.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, pending=0, FIFO count=0, starve_cnt=0.
  - Resetting mid-operation discards buffered loads and pending bits.
  - ld_ready=1 in the first cycle after reset.
  - alu_ready=1 at reset.
- pending updates one cycle after the set or commit event.
  - A set in the same cycle as a committing clear of the same register leaves the bit at 1 (set wins).

## Configuration
- REG_WB_SCOREBOARD_EN defined: pending is tracked as described. The clear happens when a FIFO pop to that register is driven onto the port.
- REG_WB_SCOREBOARD_EN undefined: pending is tied to 32'b0, iss_valid/iss_dst are ignored, and no scoreboard flops are built. Arbitration is identical.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - A wb_req_t typedef {dst[4:0], data[31:0]} used for both sources and FIFO entries.
- One sub-module, wb_fifo: a synchronous DEPTH-entry FIFO with push/pop, full/empty and count. The top-level module keeps the arbiter, the starvation counter and the scoreboard.

## Test plan
- ALU only: after reset, alu_valid with dst=5, data=0x1234 → next cycle wr_en=1, wr_addr=5, wr_data=0x1234; alu_ready stays 1.
- Load backpressure: push 4 loads (dst 8..11) while alu_valid is held high → ld_ready=0 after the 4th push. Within 5 cycles alu_ready drops for one cycle and dst=8 is written. All four loads are written in order 8, 9, 10, 11.
- Push at full with a simultaneous pop: count=DEPTH, ld_valid=1 → push refused (ld_ready=0), count becomes DEPTH-1, and the refused load is accepted the next cycle.
- Register zero: alu_dst=0 and ld_dst=0 transfers → wr_en stays 0 for both slots. iss_dst=0 → pending[0] stays 0.
- Scoreboard: iss_valid with dst=7 → pending[7]=1. When the load to 7 commits in the same cycle as a new issue to 7, pending[7] remains 1. A later commit clears it.
- Reset mid-operation: with 3 FIFO entries and pending=0x80, assert rst for one cycle → wr_en=0, pending=0, ld_ready=1, and no stale writes afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS_32 datapath types: register-file geometry and the write-back request record.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Register 0 is hard-wired; writes to it are transported but never committed.
    function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] r);
        return r == '0;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Write-back bus: ALU and load-return sources, load-issue notification, scoreboard and register-file write port.
interface reg_writeback_if;
    import mips_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0]     alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_dst;
    logic [DATA_W-1:0]     ld_data;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_dst;
    logic [NUM_REGS-1:0]   pending;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    modport master (
        output alu_valid, alu_dst, alu_data,
        output ld_valid, ld_dst, ld_data,
        output iss_valid, iss_dst,
        input  alu_ready, ld_ready, pending,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data,
        input  ld_valid, ld_dst, ld_data,
        input  iss_valid, iss_dst,
        output alu_ready, ld_ready, pending,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO for load returns; head is readable combinationally so it can be popped onto the port.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  wb_req_t                push_data_i,
    input  logic                   pop_i,
    output wb_req_t                head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    wb_req_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-back arbiter: ALU results win, buffered loads fill idle slots, starvation throttles the ALU.
// Optional load scoreboard on the pending bus is built only when REG_WB_SCOREBOARD_EN is defined.
module reg_writeback
    import mips_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    reg_writeback_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = STARVE_LIMIT[SW-1:0];
    localparam logic [CNT_W-1:0] DEPTH_CNT  = DEPTH[CNT_W-1:0];

    logic             alu_ready;
    logic             ld_ready;
    logic             alu_fire;
    logic             ld_fire;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    wb_req_t          fifo_head;
    wb_req_t          ld_req;

    logic [SW-1:0]         starve_q, starve_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    // No pop credit: a full FIFO refuses a push even in a cycle where it pops.
    assign ld_ready  = (fifo_count < DEPTH_CNT);
    assign alu_ready = (starve_q != STARVE_MAX);
    assign alu_fire  = bus.alu_valid && alu_ready;
    assign ld_fire   = bus.ld_valid && ld_ready;
    assign fifo_pop  = !fifo_empty && !alu_fire;
    assign ld_req    = '{dst: bus.ld_dst, data: bus.ld_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ld_fire),
        .push_data_i (ld_req),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (alu_fire) begin
            wr_en_d   = !is_reg_zero(bus.alu_dst);
            wr_addr_d = bus.alu_dst;
            wr_data_d = bus.alu_data;
        end else if (fifo_pop) begin
            wr_en_d   = !is_reg_zero(fifo_head.dst);
            wr_addr_d = fifo_head.dst;
            wr_data_d = fifo_head.data;
        end
        // A non-empty FIFO that did not pop necessarily lost to the ALU.
        starve_d = (fifo_empty || fifo_pop) ? '0 : starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = ld_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

`ifdef REG_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // Clear is applied before set so a same-cycle issue to the committing register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && !is_reg_zero(fifo_head.dst)) begin
            pending_d[fifo_head.dst] = 1'b0;
        end
        if (bus.iss_valid && !is_reg_zero(bus.iss_dst)) begin
            pending_d[bus.iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.pending = pending_q;
`else
    logic unused_iss;
    assign unused_iss  = ^{bus.iss_valid, bus.iss_dst};
    assign bus.pending = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a queue model predicts every committed write, scenario tasks check the edge cases.
module tb_reg_writeback;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_writeback_if bus ();

    reg_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int        cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t    expq[$];
    wb_req_t mq[$];
    int      m_starve = 0;
    int      cyc = 0;
    bit      started = 0;
    int      n_cmp = 0;
    int      n_fail = 0;
    logic [4:0] ld_seen[$];

    // Reference model: predicts arbitration from the bench's own queue of loads.
    bit      m_afire, m_lfire, m_pop, m_was_empty;
    wb_req_t m_h;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            expq.delete();
            m_starve = 0;
        end else begin
            m_was_empty = (mq.size() == 0);
            m_afire = bus.alu_valid && (m_starve != LIMIT);
            m_lfire = bus.ld_valid && (mq.size() < DEPTH);
            m_pop   = !m_was_empty && !m_afire;
            if (m_afire) begin
                if (bus.alu_dst != 0) expq.push_back('{cyc, bus.alu_dst, bus.alu_data});
            end else if (m_pop) begin
                m_h = mq.pop_front();
                if (m_h.dst != 0) expq.push_back('{cyc, m_h.dst, m_h.data});
            end
            m_starve = (m_was_empty || m_pop) ? 0 : m_starve + 1;
            if (m_lfire) mq.push_back('{dst: bus.ld_dst, data: bus.ld_data});
        end
    end

    exp_t mon_e;
    bit   mon_en;
    always @(negedge clk) begin
        if (started) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL missed_write: got no write, required addr=%0d data=%h at cycle %0d",
                         mon_e.addr, mon_e.data, mon_e.cyc);
            end
            mon_en = (expq.size() > 0 && expq[0].cyc == cyc);
            n_cmp++;
            if (bus.wr_en !== mon_en) begin
                n_fail++;
                $display("FAIL sb_wr_en: cycle %0d got %b required %b", cyc, bus.wr_en, mon_en);
            end
            if (mon_en) begin
                mon_e = expq.pop_front();
                n_cmp++;
                if ({bus.wr_addr, bus.wr_data} !== {mon_e.addr, mon_e.data}) begin
                    n_fail++;
                    $display("FAIL sb_write: cycle %0d got addr=%0d data=%h required addr=%0d data=%h",
                             cyc, bus.wr_addr, bus.wr_data, mon_e.addr, mon_e.data);
                end else begin
                    $display("write ok: cycle %0d addr=%0d data=%h", cyc, bus.wr_addr, bus.wr_data);
                end
            end
            n_cmp++;
            if (bus.alu_ready !== (m_starve != LIMIT)) begin
                n_fail++;
                $display("FAIL sb_alu_ready: cycle %0d got %b required %b", cyc, bus.alu_ready, m_starve != LIMIT);
            end
            n_cmp++;
            if (bus.ld_ready !== (mq.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL sb_ld_ready: cycle %0d got %b required %b", cyc, bus.ld_ready, mq.size() < DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.wr_en === 1'b1 && bus.wr_addr >= 8 && bus.wr_addr <= 11) ld_seen.push_back(bus.wr_addr);
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_dst = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_dst  = 0; bus.ld_data  = 0;
        bus.iss_valid = 0; bus.iss_dst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        @(posedge clk);
        started = 1;
        @(negedge clk);
        tick();
        rst = 0;
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 38'b0) begin
            n_fail++;
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h required all zero", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_cmp++;
        if (bus.pending !== 32'b0) begin
            n_fail++; $display("FAIL reset_pending: got %h required 0", bus.pending);
        end
        n_cmp++;
        if ({bus.ld_ready, bus.alu_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got ld=%b alu=%b required 1/1", bus.ld_ready, bus.alu_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_only();
        bus.alu_valid = 1; bus.alu_dst = 5; bus.alu_data = 32'h1234;
        tick();
        bus.alu_valid = 0;
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd5, 32'h1234}) begin
            n_fail++;
            $display("FAIL alu_write: got en=%b addr=%0d data=%h required 1/5/00001234", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_cmp++;
        if (bus.alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL alu_ready_hold: got %b required 1", bus.alu_ready);
        end
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL alu_one_cycle: got wr_en=%b required 0", bus.wr_en);
        end
        $display("test_alu_only done");
    endtask

    task automatic test_backpressure();
        int k;
        ld_seen.delete();
        bus.alu_valid = 1; bus.alu_dst = 20;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1; bus.ld_dst = 5'(8 + i); bus.ld_data = 32'hA000 + i;
            bus.alu_data = 32'hB000 + i;
            tick();
        end
        bus.ld_valid = 0;
        n_cmp++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ld_ready: got %b required 0 after 4 pushes", bus.ld_ready);
        end
        k = 0;
        while (bus.alu_ready === 1'b1 && k < 5) begin
            bus.alu_data = bus.alu_data + 1;
            tick();
            k++;
        end
        n_cmp++;
        if (bus.alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_throttle: got alu_ready=%b after %0d cycles required 0", bus.alu_ready, k);
        end else begin
            tick();
            n_cmp++;
            if ({bus.wr_en, bus.wr_addr} !== {1'b1, 5'd8}) begin
                n_fail++; $display("FAIL bp_first_load: got en=%b addr=%0d required 1/8", bus.wr_en, bus.wr_addr);
            end
        end
        k = 0;
        while (ld_seen.size() < 4 && k < 40) begin
            bus.alu_data = bus.alu_data + 1;
            tick();
            k++;
        end
        bus.alu_valid = 0;
        n_cmp++;
        if (ld_seen.size() != 4) begin
            n_fail++; $display("FAIL bp_drain: got %0d load writes required 4", ld_seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ld_seen[i] !== 5'(8 + i)) begin
                    n_fail++; $display("FAIL bp_order: slot %0d got addr=%0d required %0d", i, ld_seen[i], 8 + i);
                end
            end
        end
        tick();
        $display("test_backpressure done");
    endtask

    task automatic test_full_pop();
        bus.alu_valid = 1; bus.alu_dst = 21;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1; bus.ld_dst = 5'(12 + i); bus.ld_data = 32'hC000 + i;
            bus.alu_data = 32'hD000 + i;
            tick();
        end
        bus.alu_valid = 0;
        bus.ld_dst = 16; bus.ld_data = 32'hC016;
        n_cmp++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_refuse: got ld_ready=%b required 0", bus.ld_ready);
        end
        tick();
        n_cmp++;
        if ({bus.ld_ready, bus.wr_en, bus.wr_addr} !== {1'b1, 1'b1, 5'd12}) begin
            n_fail++;
            $display("FAIL full_pop: got ld_ready=%b en=%b addr=%0d required 1/1/12", bus.ld_ready, bus.wr_en, bus.wr_addr);
        end
        tick();
        bus.ld_valid = 0;
        n_cmp++;
        if ({bus.ld_ready, bus.wr_addr} !== {1'b1, 5'd13}) begin
            n_fail++; $display("FAIL push_pop: got ld_ready=%b addr=%0d required 1/13", bus.ld_ready, bus.wr_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.wr_en, bus.wr_addr} !== {1'b1, 5'(14 + i)}) begin
                n_fail++; $display("FAIL full_drain: got en=%b addr=%0d required 1/%0d", bus.wr_en, bus.wr_addr, 14 + i);
            end
        end
        tick();
        $display("test_full_pop done");
    endtask

    task automatic test_reg_zero();
        bus.alu_valid = 1; bus.alu_dst = 0; bus.alu_data = 32'hDEAD;
        tick();
        bus.alu_valid = 0;
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL zero_alu: got wr_en=%b required 0", bus.wr_en);
        end
        bus.ld_valid = 1; bus.ld_dst = 0; bus.ld_data = 32'hBEEF;
        tick();
        bus.ld_valid = 0;
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL zero_load: got wr_en=%b required 0", bus.wr_en);
        end
        bus.iss_valid = 1; bus.iss_dst = 0;
        tick();
        bus.iss_valid = 0;
        n_cmp++;
        if (bus.pending !== 32'b0) begin
            n_fail++; $display("FAIL zero_pending: got %h required 0", bus.pending);
        end
        $display("test_reg_zero done");
    endtask

    task automatic test_scoreboard();
        bus.iss_valid = 1; bus.iss_dst = 7;
        tick();
        bus.iss_valid = 0;
`ifdef REG_WB_SCOREBOARD_EN
        n_cmp++;
        if (bus.pending !== 32'h80) begin
            n_fail++; $display("FAIL sb_set: got %h required 00000080", bus.pending);
        end
        bus.ld_valid = 1; bus.ld_dst = 7; bus.ld_data = 32'h77;
        tick();
        bus.ld_valid = 0;
        bus.iss_valid = 1; bus.iss_dst = 7;
        tick();
        bus.iss_valid = 0;
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.pending} !== {1'b1, 5'd7, 32'h80}) begin
            n_fail++;
            $display("FAIL sb_set_wins: got en=%b addr=%0d pending=%h required 1/7/00000080", bus.wr_en, bus.wr_addr, bus.pending);
        end
        bus.ld_valid = 1; bus.ld_dst = 7; bus.ld_data = 32'h78;
        tick();
        bus.ld_valid = 0;
        tick();
        n_cmp++;
        if (bus.pending !== 32'b0) begin
            n_fail++; $display("FAIL sb_clear: got %h required 0", bus.pending);
        end
`else
        n_cmp++;
        if (bus.pending !== 32'b0) begin
            n_fail++; $display("FAIL sb_disabled: got %h required 0", bus.pending);
        end
`endif
        $display("test_scoreboard done");
    endtask

    task automatic test_reset_mid();
        bus.iss_valid = 1; bus.iss_dst = 7;
        bus.alu_valid = 1; bus.alu_dst = 22;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1; bus.ld_dst = 5'(24 + i); bus.ld_data = 32'hE000 + i;
            bus.alu_data = 32'hF000 + i;
            tick();
            bus.iss_valid = 0;
        end
        rst = 1;
        idle();
        tick();
        rst = 0;
        n_cmp++;
        if ({bus.wr_en, bus.ld_ready, bus.alu_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL mid_reset: got en=%b ld_ready=%b alu_ready=%b required 0/1/1", bus.wr_en, bus.ld_ready, bus.alu_ready);
        end
        n_cmp++;
        if (bus.pending !== 32'b0) begin
            n_fail++; $display("FAIL mid_reset_pending: got %h required 0", bus.pending);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (bus.wr_en !== 1'b0) begin
                n_fail++; $display("FAIL stale_write: cycle %0d got addr=%0d required no write", cyc, bus.wr_addr);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_backpressure();
        test_full_pop();
        test_reg_zero();
        test_scoreboard();
        test_reset_mid();
        n_cmp++;
        if (expq.size() != 0) begin
            n_fail++; $display("FAIL leftover: got %0d unseen writes required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
